// File: rtl/reg_rename_file_pkg.sv
// Shared widths, bus types and the commit payload for the rename register file.
package reg_rename_file_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned TAG_W   = 5;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]  reg_val_t;
  typedef logic [TAG_W-1:0] rob_tag_t;

  localparam rob_tag_t NULL_TAG = TAG_W'(0);

  typedef struct packed {
    logic     vld;
    reg_idx_t rd;
    reg_val_t val;
    rob_tag_t tag;
  } commit_t;

endpackage

// File: rtl/reg_rename_file_read_port.sv
// One operand lookup: hardwired x0, same-cycle commit bypass, else stored tag/value.
module reg_read_port
  import reg_rename_file_pkg::*;
(
  input  reg_idx_t i_idx,
  input  rob_tag_t i_tag,
  input  reg_val_t i_val,
  input  commit_t  i_commit,
  output rob_tag_t o_rely,
  output reg_val_t o_val
);

  // Bypass only when the committing entry is still the register's owner.
  always_comb begin
    o_rely = i_tag;
    o_val  = i_val;
    if (i_idx == REG_W'(0)) begin
      o_rely = NULL_TAG;
      o_val  = XLEN'(0);
    end else if (i_commit.vld && (i_commit.rd == i_idx) && (i_tag == i_commit.tag)) begin
      o_rely = NULL_TAG;
      o_val  = i_commit.val;
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags, commit writes and flush.
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  input  logic                 dispatch_rdy,
  input  logic [REG_W-1:0]     dispatch_rd,
  input  logic [TAG_W-1:0]     dispatch_tag,
  input  logic [REG_W-1:0]     rs1_idx,
  input  logic [REG_W-1:0]     rs2_idx,
  output logic [TAG_W-1:0]     rs1_rely,
  output logic [XLEN-1:0]      rs1_val,
  output logic [TAG_W-1:0]     rs2_rely,
  output logic [XLEN-1:0]      rs2_val,
  input  logic                 write_rdy,
  input  logic [REG_W-1:0]     to_rd,
  input  logic [XLEN-1:0]      write_val,
  input  logic [TAG_W-1:0]     commit_tag
);

  reg_val_t r_regs [REG_NUM];
  rob_tag_t r_tag  [REG_NUM];

  commit_t  w_commit;
  rob_tag_t w_rs1_rely, w_rs2_rely;
  reg_val_t w_rs1_val, w_rs2_val;

  assign w_commit = '{vld: write_rdy, rd: to_rd, val: write_val, tag: commit_tag};

  // Later assignments win: dispatch overrides commit-retire, clear overrides both.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= XLEN'(0);
        r_tag[i]  <= NULL_TAG;
      end
    end else if (rdy_in) begin
      if (write_rdy && (to_rd != REG_W'(0))) begin
        r_regs[to_rd] <= write_val;
        if (r_tag[to_rd] == commit_tag) begin
          r_tag[to_rd] <= NULL_TAG;
        end
      end
      if (clear_in) begin
        for (int unsigned i = 0; i < REG_NUM; i++) begin
          r_tag[i] <= NULL_TAG;
        end
      end else if (dispatch_rdy && (dispatch_rd != REG_W'(0))) begin
        r_tag[dispatch_rd] <= dispatch_tag;
      end
    end
  end

  reg_read_port u_rs1 (
    .i_idx    (rs1_idx),
    .i_tag    (r_tag[rs1_idx]),
    .i_val    (r_regs[rs1_idx]),
    .i_commit (w_commit),
    .o_rely   (w_rs1_rely),
    .o_val    (w_rs1_val)
  );

  reg_read_port u_rs2 (
    .i_idx    (rs2_idx),
    .i_tag    (r_tag[rs2_idx]),
    .i_val    (r_regs[rs2_idx]),
    .i_commit (w_commit),
    .o_rely   (w_rs2_rely),
    .o_val    (w_rs2_val)
  );

  assign rs1_rely = w_rs1_rely;
  assign rs1_val  = w_rs1_val;
  assign rs2_rely = w_rs2_rely;
  assign rs2_val  = w_rs2_val;

endmodule

// File: tb/tb_reg_rename_file.sv
// Table-driven directed bench for reg_rename_file plus a hand-written async reset sequence.
module tb_reg_rename_file;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in, clear_in, dispatch_rdy, write_rdy;
  logic [4:0]  dispatch_rd, dispatch_tag, rs1_idx, rs2_idx, to_rd, commit_tag;
  logic [4:0]  rs1_rely, rs2_rely;
  logic [31:0] rs1_val, rs2_val, write_val;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rdy, clr, drdy, wr;
    logic [4:0]  drd, dtag, rs1, rs2, trd, ctag, e1t, e2t;
    logic [31:0] wval, e1v, e2v;
  } vec_t;

  vec_t vecs [22];

  always #5 clk_in = ~clk_in;

  reg_rename_file dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .clear_in     (clear_in),
    .dispatch_rdy (dispatch_rdy),
    .dispatch_rd  (dispatch_rd),
    .dispatch_tag (dispatch_tag),
    .rs1_idx      (rs1_idx),
    .rs2_idx      (rs2_idx),
    .rs1_rely     (rs1_rely),
    .rs1_val      (rs1_val),
    .rs2_rely     (rs2_rely),
    .rs2_val      (rs2_val),
    .write_rdy    (write_rdy),
    .to_rd        (to_rd),
    .write_val    (write_val),
    .commit_tag   (commit_tag)
  );

  function automatic vec_t mk(int rdy, int clr, int drdy, int drd, int dtag,
                              int rs1, int rs2, int wr, int trd, int wval, int ctag,
                              int e1t, int e1v, int e2t, int e2v);
    vec_t v;
    v.rdy = 1'(rdy);   v.clr = 1'(clr);   v.drdy = 1'(drdy);
    v.drd = 5'(drd);   v.dtag = 5'(dtag);
    v.rs1 = 5'(rs1);   v.rs2 = 5'(rs2);
    v.wr  = 1'(wr);    v.trd = 5'(trd);   v.wval = 32'(wval); v.ctag = 5'(ctag);
    v.e1t = 5'(e1t);   v.e1v = 32'(e1v);  v.e2t = 5'(e2t);    v.e2v = 32'(e2v);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle(input logic [4:0] r1, input logic [4:0] r2);
    rdy_in = 1'b1; clear_in = 1'b0; dispatch_rdy = 1'b0; write_rdy = 1'b0;
    dispatch_rd = 5'd0; dispatch_tag = 5'd0; to_rd = 5'd0; write_val = 32'd0;
    commit_tag = 5'd0; rs1_idx = r1; rs2_idx = r2;
  endtask

  initial begin
    //            rdy clr drdy drd dtag rs1 rs2 wr trd wval     ctag e1t e1v      e2t e2v
    vecs[0]  = mk(1, 0, 1, 5, 3, 5, 0, 0, 0, 0,       0, 0, 0,       0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 5, 0, 0, 0, 0,       0, 3, 0,       0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 5, 5, 1, 5, 'h1234,  3, 0, 'h1234,  0, 'h1234);
    vecs[3]  = mk(1, 0, 0, 0, 0, 5, 5, 0, 0, 0,       0, 0, 'h1234,  0, 'h1234);
    vecs[4]  = mk(1, 0, 1, 5, 3, 5, 0, 0, 0, 0,       0, 0, 'h1234,  0, 0);
    vecs[5]  = mk(1, 0, 1, 5, 7, 5, 0, 0, 0, 0,       0, 3, 'h1234,  0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 5, 0, 1, 5, 'hAA,    3, 7, 'h1234,  0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 5, 0, 0, 0, 0,       0, 7, 'hAA,    0, 0);
    vecs[8]  = mk(1, 0, 1, 6, 2, 6, 0, 0, 0, 0,       0, 0, 0,       0, 0);
    vecs[9]  = mk(1, 0, 1, 6, 9, 6, 0, 1, 6, 'h66,    2, 0, 'h66,    0, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 6, 0, 0, 0, 0,       0, 9, 'h66,    0, 0);
    vecs[11] = mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0);
    vecs[12] = mk(1, 0, 1, 2, 2, 1, 0, 0, 0, 0,       0, 1, 0,       0, 0);
    vecs[13] = mk(1, 0, 1, 3, 4, 2, 1, 0, 0, 0,       0, 2, 0,       1, 0);
    vecs[14] = mk(1, 1, 1, 7, 5, 3, 4, 1, 4, 'h55,    6, 4, 0,       0, 0);
    vecs[15] = mk(1, 0, 0, 0, 0, 3, 4, 0, 0, 0,       0, 0, 0,       0, 'h55);
    vecs[16] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,       0, 0, 0,       0, 0);
    vecs[17] = mk(1, 0, 0, 0, 0, 5, 6, 0, 0, 0,       0, 0, 'hAA,    0, 'h66);
    vecs[18] = mk(1, 0, 1, 0, 4, 0, 0, 1, 0, 'hFF,    0, 0, 0,       0, 0);
    vecs[19] = mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 0,       0, 0, 0,       0, 0);
    vecs[20] = mk(0, 0, 1, 5, 8, 5, 0, 1, 5, 'hBB,    3, 0, 'hAA,    0, 0);
    vecs[21] = mk(1, 0, 0, 0, 0, 5, 0, 0, 0, 0,       0, 0, 'hAA,    0, 0);

    drive_idle(5'd5, 5'd6);
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    chk("reset_rs1_rely", 32'(rs1_rely), 32'd0);
    chk("reset_rs1_val",  rs1_val,       32'd0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk_in);
      rdy_in = vecs[i].rdy;   clear_in = vecs[i].clr;
      dispatch_rdy = vecs[i].drdy; dispatch_rd = vecs[i].drd; dispatch_tag = vecs[i].dtag;
      rs1_idx = vecs[i].rs1;  rs2_idx = vecs[i].rs2;
      write_rdy = vecs[i].wr; to_rd = vecs[i].trd; write_val = vecs[i].wval;
      commit_tag = vecs[i].ctag;
      #1;
      chk($sformatf("v%0d_rs1_rely", i), 32'(rs1_rely), 32'(vecs[i].e1t));
      chk($sformatf("v%0d_rs1_val", i),  rs1_val,       vecs[i].e1v);
      chk($sformatf("v%0d_rs2_rely", i), 32'(rs2_rely), 32'(vecs[i].e2t));
      chk($sformatf("v%0d_rs2_val", i),  rs2_val,       vecs[i].e2v);
    end

    // Async reset mid-run: tag x5 first so reset visibly clears a tag and a value.
    @(negedge clk_in);
    drive_idle(5'd5, 5'd6);
    dispatch_rdy = 1'b1; dispatch_rd = 5'd5; dispatch_tag = 5'd12;
    @(negedge clk_in);
    drive_idle(5'd5, 5'd6);
    #1;
    chk("pre_reset_rs1_rely", 32'(rs1_rely), 32'd12);
    chk("pre_reset_rs1_val",  rs1_val,       32'hAA);
    chk("pre_reset_rs2_val",  rs2_val,       32'h66);
    rst_n_in = 1'b0;
    #1;
    chk("async_reset_rs1_rely", 32'(rs1_rely), 32'd0);
    chk("async_reset_rs1_val",  rs1_val,       32'd0);
    chk("async_reset_rs2_val",  rs2_val,       32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
    chk("post_reset_rs1_rely", 32'(rs1_rely), 32'd0);
    chk("post_reset_rs1_val",  rs1_val,       32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
